// File: rtl/temp_valve_sequencer.sv
// rtl/temp_valve_sequencer.sv - water temperature valve sequencer (SETTLE/FILL/CLOSE)
// Optional level sensor input enabled by TEMP_NIVEL_SENSOR_EN.
module temp_valve_sequencer #(
    parameter int FILL_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int PWM_PERIOD    = 8,
    parameter int WARM_DUTY     = 4
) (
    input  logic       iClk,
    input  logic       iReset_Temperatura,
    input  logic [1:0] iEstado_Temp,
    input  logic       iReq,
    input  logic       iAbort,
`ifdef TEMP_NIVEL_SENSOR_EN
    input  logic       iNivel_Lleno,
`endif
    output logic       oAck,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAbortado,
    output logic       oValvula_Caliente,
    output logic       oValvula_Fria,
    output logic [3:0] oLed_Estado
);

    localparam logic [15:0] FILL_LAST   = 16'(FILL_CYCLES - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  PWM_LAST    = 8'(PWM_PERIOD - 1);
    localparam logic [7:0]  DUTY        = 8'(WARM_DUTY);

    typedef enum logic [1:0] {IDLE, SETTLE, FILL, CLOSE} state_t;

    state_t      state, stateNext;
    logic        armed, armedNext;
    logic [1:0]  mode, modeNext;
    logic [7:0]  settleCnt, settleNext;
    logic [15:0] fillCnt, fillNext;
    logic [7:0]  pwmCnt, pwmNext;
    logic        ackNext, doneNext, abortNext, busyNext, hotNext, coldNext;
    logic [3:0]  ledNext;
    logic        nivelLleno;

`ifdef TEMP_NIVEL_SENSOR_EN
    logic [1:0] nivelSync;
    always_ff @(posedge iClk or negedge iReset_Temperatura) begin
        if (!iReset_Temperatura) nivelSync <= 2'b00;
        else                     nivelSync <= {nivelSync[0], iNivel_Lleno};
    end
    assign nivelLleno = nivelSync[1];
`else
    assign nivelLleno = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iReset_Temperatura) begin
        if (!iReset_Temperatura) begin
            state             <= IDLE;
            armed             <= 1'b1;
            mode              <= 2'b00;
            settleCnt         <= 8'd0;
            fillCnt           <= 16'd0;
            pwmCnt            <= 8'd0;
            oAck              <= 1'b0;
            oBusy             <= 1'b0;
            oDone             <= 1'b0;
            oAbortado         <= 1'b0;
            oValvula_Caliente <= 1'b0;
            oValvula_Fria     <= 1'b0;
            oLed_Estado       <= 4'b0000;
        end else begin
            state             <= stateNext;
            armed             <= armedNext;
            mode              <= modeNext;
            settleCnt         <= settleNext;
            fillCnt           <= fillNext;
            pwmCnt            <= pwmNext;
            oAck              <= ackNext;
            oBusy             <= busyNext;
            oDone             <= doneNext;
            oAbortado         <= abortNext;
            oValvula_Caliente <= hotNext;
            oValvula_Fria     <= coldNext;
            oLed_Estado       <= ledNext;
        end
    end

    always_comb begin
        stateNext  = state;
        armedNext  = armed;
        modeNext   = mode;
        settleNext = settleCnt;
        fillNext   = fillCnt;
        pwmNext    = pwmCnt;
        ackNext    = 1'b0;
        doneNext   = 1'b0;
        abortNext  = 1'b0;
        hotNext    = 1'b0;
        coldNext   = 1'b0;

        case (state)
            IDLE: begin
                if (iReq && !iAbort && armed) begin
                    stateNext  = SETTLE;
                    armedNext  = 1'b0;
                    modeNext   = iEstado_Temp;
                    settleNext = 8'd0;
                    ackNext    = 1'b1;
                end
            end
            SETTLE: begin
                if (iAbort) begin
                    stateNext = CLOSE;
                    abortNext = 1'b1;
                end else if (nivelLleno) begin
                    stateNext = CLOSE;
                    doneNext  = 1'b1;
                end else if (settleCnt == SETTLE_LAST) begin
                    stateNext = FILL;
                    fillNext  = 16'd0;
                    pwmNext   = 8'd0;
                end else begin
                    settleNext = settleCnt + 8'd1;
                end
            end
            FILL: begin
                if (iAbort) begin
                    stateNext = CLOSE;
                    abortNext = 1'b1;
                end else if (nivelLleno || fillCnt == FILL_LAST) begin
                    stateNext = CLOSE;
                    doneNext  = 1'b1;
                end else begin
                    fillNext = fillCnt + 16'd1;
                    pwmNext  = (pwmCnt == PWM_LAST) ? 8'd0 : pwmCnt + 8'd1;
                end
            end
            default: begin
                stateNext  = IDLE;
                settleNext = 8'd0;
                fillNext   = 16'd0;
                pwmNext    = 8'd0;
            end
        endcase

        // Re-arm only once the requester has released iReq.
        if (!iReq) armedNext = 1'b1;

        busyNext = (stateNext != IDLE);
        ledNext  = busyNext ? (4'b0001 << modeNext) : 4'b0000;

        if (stateNext == FILL) begin
            case (modeNext)
                2'b00: begin hotNext = 1'b1; coldNext = 1'b1; end
                2'b01: hotNext  = 1'b1;
                2'b10: begin
                    hotNext  = (pwmNext < DUTY);
                    coldNext = !(pwmNext < DUTY);
                end
                default: coldNext = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_valve_sequencer.sv
// tb/tb_temp_valve_sequencer.sv - self-checking bench for temp_valve_sequencer
module tb_temp_valve_sequencer;

    localparam int F = 20;
    localparam int S = 4;
    localparam int P = 8;
    localparam int D = 4;

    logic       iClk = 1'b0;
    logic       iReset_Temperatura = 1'b1;
    logic [1:0] iEstado_Temp = 2'b00;
    logic       iReq = 1'b0;
    logic       iAbort = 1'b0;
    logic       oAck, oBusy, oDone, oAbortado, oValvula_Caliente, oValvula_Fria;
    logic [3:0] oLed_Estado;
`ifdef TEMP_NIVEL_SENSOR_EN
    logic       iNivel_Lleno = 1'b0;
`endif

    temp_valve_sequencer #(
        .FILL_CYCLES(F), .SETTLE_CYCLES(S), .PWM_PERIOD(P), .WARM_DUTY(D)
    ) dut (
        .iClk(iClk),
        .iReset_Temperatura(iReset_Temperatura),
        .iEstado_Temp(iEstado_Temp),
        .iReq(iReq),
        .iAbort(iAbort),
`ifdef TEMP_NIVEL_SENSOR_EN
        .iNivel_Lleno(iNivel_Lleno),
`endif
        .oAck(oAck),
        .oBusy(oBusy),
        .oDone(oDone),
        .oAbortado(oAbortado),
        .oValvula_Caliente(oValvula_Caliente),
        .oValvula_Fria(oValvula_Fria),
        .oLed_Estado(oLed_Estado)
    );

    always #5 iClk = ~iClk;

    int vecs = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 running (r = clocks since acceptance), 2 closing.
    int         phase = 0;
    int         r = 0;
    logic [1:0] mMode = 2'b00;
    logic       mArmed = 1'b1;
    logic       eAck = 0, eDone = 0, eAb = 0, eBusy = 0, eHot = 0, eCold = 0;
    logic [3:0] eLed = 4'b0000;

    always @(posedge iClk or negedge iReset_Temperatura) begin
        if (!iReset_Temperatura) begin
            phase = 0; r = 0; mMode = 2'b00; mArmed = 1'b1;
            eAck = 0; eDone = 0; eAb = 0;
        end else begin
            eAck = 0; eDone = 0; eAb = 0;
            if (phase == 0) begin
                if (iReq && !iAbort && mArmed) begin
                    phase = 1; r = 0; mMode = iEstado_Temp; eAck = 1; mArmed = 0;
                end
            end else if (phase == 1) begin
                if (iAbort) begin
                    phase = 2; eAb = 1;
                end else begin
                    r++;
                    if (r == S + F) begin phase = 2; eDone = 1; end
                end
            end else begin
                phase = 0;
            end
            if (!iReq) mArmed = 1'b1;
        end
        eBusy = (phase != 0);
        eLed  = eBusy ? 4'(1 << mMode) : 4'b0000;
        eHot  = 0;
        eCold = 0;
        if (phase == 1 && r >= S) begin
            case (mMode)
                2'b00: begin eHot = 1; eCold = 1; end
                2'b01: eHot = 1;
                2'b10: begin eHot = ((r - S) % P) < D; eCold = !eHot; end
                default: eCold = 1;
            endcase
        end
    end

    always @(negedge iClk) begin
        chk("cycle", {22'd0, oAck, oBusy, oDone, oAbortado, oValvula_Caliente, oValvula_Fria, oLed_Estado},
                     {22'd0, eAck, eBusy, eDone, eAb, eHot, eCold, eLed});
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge iClk); #1; end
    endtask

    int hotCnt, coldCnt, doneCnt, ackCnt, both;
    logic [19:0] pat;

    initial begin
        #2 iReset_Temperatura = 1'b0;
        cyc(3);
        chk("reset_outputs", {oAck, oBusy, oDone, oAbortado, oValvula_Caliente, oValvula_Fria, oLed_Estado}, 10'd0);
        iReset_Temperatura = 1'b1;
        cyc(1);

        // caliente
        iEstado_Temp = 2'b01; iReq = 1'b1;
        cyc(1);
        chk("hot_ack", oAck, 1);
        chk("hot_led", oLed_Estado, 4'b0010);
        chk("hot_settle_valves", {oValvula_Caliente, oValvula_Fria}, 2'b00);
        iReq = 1'b0;
        hotCnt = 0; coldCnt = 0; doneCnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            hotCnt += oValvula_Caliente; coldCnt += oValvula_Fria; doneCnt += oDone;
        end
        chk("hot_clocks", hotCnt, 20);
        chk("hot_cold_clocks", coldCnt, 0);
        chk("hot_done_pulses", doneCnt, 1);
        chk("hot_idle_busy", oBusy, 0);

        // tibia PWM pattern
        iEstado_Temp = 2'b10; iReq = 1'b1;
        cyc(1);
        iReq = 1'b0;
        cyc(4);
        pat = '0; both = 0;
        for (int i = 0; i < 20; i++) begin
            pat[19 - i] = oValvula_Caliente;
            if (oValvula_Caliente && oValvula_Fria) both++;
            if (oValvula_Caliente == oValvula_Fria) both++;
            cyc(1);
        end
        chk("warm_pattern", pat, 20'b11110000111100001111);
        chk("warm_exclusive", both, 0);
        cyc(3);

        // fria with iReq held high
        iEstado_Temp = 2'b11; iReq = 1'b1;
        ackCnt = 0; coldCnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            ackCnt += oAck; coldCnt += oValvula_Fria;
        end
        chk("held_req_acks", ackCnt, 1);
        chk("held_req_cold", coldCnt, 20);
        iReq = 1'b0;
        cyc(1);
        iReq = 1'b1;
        cyc(1);
        chk("rearm_ack", oAck, 1);
        iReq = 1'b0;
        cyc(30);

        // abort at FILL clock 7, ambiente
        iEstado_Temp = 2'b00; iReq = 1'b1;
        cyc(1);
        iReq = 1'b0;
        cyc(11);
        chk("amb_valves", {oValvula_Caliente, oValvula_Fria}, 2'b11);
        iAbort = 1'b1;
        cyc(1);
        chk("abort_close", {oValvula_Caliente, oValvula_Fria, oAbortado, oDone, oBusy}, 5'b00101);
        iAbort = 1'b0;
        cyc(1);
        chk("abort_idle", {oBusy, oDone, oAbortado}, 3'b000);

        // iReq with iAbort in IDLE is refused, then accepted once iAbort drops
        iReq = 1'b1; iAbort = 1'b1;
        cyc(1);
        chk("idle_abort_noack", {oAck, oBusy}, 2'b00);
        iAbort = 1'b0;
        cyc(1);
        chk("idle_after_abort_ack", oAck, 1);
        iReq = 1'b0;
        cyc(30);

        // reset mid-FILL
        iEstado_Temp = 2'b01; iReq = 1'b1;
        cyc(1);
        iReq = 1'b0;
        cyc(10);
        chk("midfill_hot", oValvula_Caliente, 1);
        #1 iReset_Temperatura = 1'b0;
        #1 chk("async_reset", {oAck, oBusy, oDone, oAbortado, oValvula_Caliente, oValvula_Fria, oLed_Estado}, 10'd0);
        cyc(2);
        iReset_Temperatura = 1'b1;
        iReq = 1'b1;
        cyc(1);
        chk("post_reset_ack", oAck, 1);
        iReq = 1'b0;
        hotCnt = 0; doneCnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            hotCnt += oValvula_Caliente; doneCnt += oDone;
        end
        chk("post_reset_hot", hotCnt, 20);
        chk("post_reset_done", doneCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/temp_valve_sequencer.md
TEMP_VALVE_SEQUENCER -- requirements
Module: temp_valve_sequencer

Interface
REQ-001 SHALL have parameter FILL_CYCLES, default 1000, meaning FILL duration in clocks (1..65535).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, meaning valves-closed dead time before FILL (1..255).
REQ-003 SHALL have parameter PWM_PERIOD, default 8, meaning warm-mode alternation period in clocks (2..255).
REQ-004 SHALL have parameter WARM_DUTY, default 4, meaning hot-valve clocks per PWM_PERIOD in warm mode (1..PWM_PERIOD-1).
REQ-005 SHALL have port iClk  input  1  rising-edge clock.
REQ-006 SHALL have port iReset_Temperatura  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port iEstado_Temp  input  2  requested mode: 00 ambiente, 01 caliente, 10 tibia, 11 fria.
REQ-008 SHALL have port iReq  input  1  start request, level.
REQ-009 SHALL have port iAbort  input  1  abort in-progress cycle.
REQ-010 SHALL have port oAck  output  1  one-clock pulse, request accepted.
REQ-011 SHALL have port oBusy  output  1  high in SETTLE, FILL, CLOSE.
REQ-012 SHALL have port oDone  output  1  one-clock pulse, cycle completed normally.
REQ-013 SHALL have port oAbortado  output  1  one-clock pulse, cycle aborted.
REQ-014 SHALL have ports oValvula_Caliente, oValvula_Fria  output  1 each  valve drives.
REQ-015 SHALL have port oLed_Estado  output  4  one-hot latched mode (bit0 ambiente .. bit3 fria), 0000 when idle.

Function
REQ-016 SHALL implement FSM IDLE, SETTLE, FILL, CLOSE; all outputs registered.
REQ-017 SHALL accept in IDLE at an edge where iReq=1, iAbort=0 and armed; -> SETTLE, latch iEstado_Temp, oAck=1 next cycle, counter=0.
REQ-018 SHALL clear armed on accept and set it on any edge with iReq=0; held-high iReq never triggers a second cycle.
REQ-019 SHALL keep both valves 0 for exactly SETTLE_CYCLES clocks in SETTLE, then -> FILL.
REQ-020 SHALL remain in FILL exactly FILL_CYCLES clocks with valves per latched mode: ambiente both 1; caliente hot only; fria cold only.
REQ-021 SHALL in tibia drive hot for the first WARM_DUTY clocks of each PWM_PERIOD window, cold for the rest; never both 1 in tibia; PWM phase restarts at FILL entry.
REQ-022 SHALL go FILL -> CLOSE at count FILL_CYCLES-1; CLOSE lasts 1 clock with valves 0, oDone=1, then IDLE.
REQ-023 SHALL on iAbort=1 in SETTLE or FILL go to CLOSE next edge: valves 0, oAbortado=1, oDone=0.
REQ-024 SHALL ignore iAbort in IDLE and CLOSE; iReq with iAbort in IDLE is not accepted.
REQ-025 SHALL ignore iEstado_Temp and iReq while oBusy=1.
REQ-026 SHALL use a 16-bit fill counter and 8-bit settle/PWM counters, no wrap within a phase.

Reset
REQ-027 SHALL on iReset_Temperatura=0 immediately force IDLE, armed=1, all counters 0, all outputs 0, including mid-FILL (valves close without oDone/oAbortado).
REQ-028 SHALL resume operation on the first clock edge after reset deassertion.

Configuration
REQ-029 SHALL, with TEMP_NIVEL_SENSOR_EN defined, add port iNivel_Lleno input 1, synchronized by two flops; synchronized 1 in FILL -> CLOSE with oDone=1 early; synchronized 1 in SETTLE -> CLOSE with oDone=1, valves never opened.
REQ-030 SHALL, without TEMP_NIVEL_SENSOR_EN, omit iNivel_Lleno; FILL ends on timer only.

Verification (FILL_CYCLES=20, SETTLE_CYCLES=4, PWM_PERIOD=8, WARM_DUTY=4)
REQ-031 SHALL cover: reset, iEstado_Temp=01, iReq pulse -> oAck 1 clock later, valves 00 for 4 clocks, hot=1 cold=0 for 20 clocks, oDone 1 clock, oLed_Estado=0010 while busy.
REQ-032 SHALL cover: iEstado_Temp=10 -> hot pattern 1111 0000 1111 0000 1111, cold its complement, never both 1.
REQ-033 SHALL cover: iReq held high 100 clocks, mode 11 -> exactly one cycle, one oAck; drop and reassert iReq -> second cycle.
REQ-034 SHALL cover: iAbort at FILL clock 7, mode 00 -> both valves 0 next clock, oAbortado=1, no oDone, IDLE after.
REQ-035 SHALL cover: iReset_Temperatura low mid-FILL -> all outputs 0 asynchronously; new request after release runs full cycle.
REQ-036 SHALL cover (TEMP_NIVEL_SENSOR_EN): iNivel_Lleno rises at FILL clock 5 -> valves 0 within 3 clocks, oDone=1.
